// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two requesters, the clear controller and the 1024x10 RAM macro.
// The arbiter connects through the slave modport; requesters and the RAM connect through master.
interface ram_port_arbiter_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 10
);
  logic          clr_req;
  logic          clr_busy;
  logic          clr_done;

  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  logic          ram_cs;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  clr_req,
    output clr_busy, clr_done,
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_cs, ram_write, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output clr_req,
    input  clr_busy, clr_done,
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_cs, ram_write, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin two-port arbiter for the single-port ram_reset macro, with a hardware
// full-array clear sequencer and a 1-bit owner tag that routes read data back.
module ram_port_arbiter #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 10
) (
  input  logic               clk_reset,
  input  logic               reset,
  ram_port_arbiter_if.slave  bus
);

  localparam int unsigned   DEPTH     = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          last_b_q, last_b_d;
  logic          cs_q, cs_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          tag_q, tag_d;
  logic          done_q, done_d;

  logic          rd2_q;
  logic          tag2_q;
  logic          a_rvalid_q, b_rvalid_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;

  logic          a_win_c, b_win_c, open_c, a_gnt_c, b_gnt_c;

  // Arbitration: a lone requester wins; under contention the port not granted last wins.
  always_comb begin
    a_win_c = bus.a_req & (~bus.b_req | last_b_q);
    b_win_c = bus.b_req & (~bus.a_req | ~last_b_q);
    open_c  = (state_q == IDLE) & ~bus.clr_req;
    a_gnt_c = open_c & a_win_c;
    b_gnt_c = open_c & b_win_c;
  end

  // Next-state and registered RAM command; ram_addr doubles as the clear sweep counter.
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    cs_d     = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    tag_d    = tag_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cs_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = '0;
          din_d   = '0;
        end else if (a_gnt_c) begin
          cs_d     = 1'b1;
          we_d     = bus.a_we;
          addr_d   = bus.a_addr;
          din_d    = bus.a_wdata;
          tag_d    = 1'b0;
          last_b_d = 1'b0;
        end else if (b_gnt_c) begin
          cs_d     = 1'b1;
          we_d     = bus.b_we;
          addr_d   = bus.b_addr;
          din_d    = bus.b_wdata;
          tag_d    = 1'b1;
          last_b_d = 1'b1;
        end
      end
      CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cs_d   = 1'b1;
          we_d   = 1'b1;
          addr_d = addr_q + AW'(1);
          din_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_reset or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      tag_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      tag_q    <= tag_d;
      done_q   <= done_d;
    end
  end

  // Read return: the owner tag follows the command one stage while the RAM produces data.
  always_ff @(posedge clk_reset or negedge reset) begin
    if (!reset) begin
      rd2_q      <= 1'b0;
      tag2_q     <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      rd2_q      <= cs_q & ~we_q;
      tag2_q     <= tag_q;
      a_rvalid_q <= rd2_q & ~tag2_q;
      b_rvalid_q <= rd2_q & tag2_q;
      if (rd2_q & ~tag2_q) a_rdata_q <= bus.ram_dout;
      if (rd2_q & tag2_q)  b_rdata_q <= bus.ram_dout;
    end
  end

  assign bus.a_gnt     = a_gnt_c;
  assign bus.b_gnt     = b_gnt_c;
  assign bus.clr_busy  = (state_q == CLEAR);
  assign bus.clr_done  = done_q;
  assign bus.ram_cs    = cs_q;
  assign bus.ram_write = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_din   = din_q;
  assign bus.a_rvalid  = a_rvalid_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rvalid  = b_rvalid_q;
  assign bus.b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized scoreboard bench for ram_port_arbiter with a behavioural RAM and a
// memory-array reference model; read data is checked by an independent monitor.
module tb_ram_port_arbiter;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 10;
  localparam int          DEPTH = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  ram_port_arbiter #(.AW(AW), .DW(DW)) dut (.clk_reset(clk), .reset(rst_n), .bus(bus.slave));

  // Behavioural single-port RAM: synchronous write, registered read.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ram_q;
  assign bus.ram_dout = ram_q;
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_write)  ram_mem[bus.ram_addr] <= bus.ram_din;
    if (bus.ram_cs && !bus.ram_write) ram_q <= ram_mem[bus.ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  rd_t exp_a[$];
  rd_t exp_b[$];
  rd_t ea, eb;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_last_b;
  int            m_clear_left;
  bit            m_done_next;
  bit            m_cmd_valid;
  bit            m_cmd_we;
  logic [AW-1:0] m_cmd_addr;
  logic [DW-1:0] m_cmd_din;
  int            sweep_err;
  int            busy_cycles;
  bit            dut_ag, dut_bg;

  // Read-data monitor: pops the scoreboard whenever a port presents rvalid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.a_rvalid) begin
        if (exp_a.size() == 0) chk("a_rvalid_unexpected", 1, 0);
        else begin
          ea = exp_a.pop_front();
          chk("a_rdata", bus.a_rdata, ea.data);
          chk("a_rvalid_cycle", cyc, ea.due);
        end
      end else if (exp_a.size() > 0 && exp_a[0].due <= cyc) begin
        void'(exp_a.pop_front());
        chk("a_rvalid_missing", 0, 1);
      end
      if (bus.b_rvalid) begin
        if (exp_b.size() == 0) chk("b_rvalid_unexpected", 1, 0);
        else begin
          eb = exp_b.pop_front();
          chk("b_rdata", bus.b_rdata, eb.data);
          chk("b_rvalid_cycle", cyc, eb.due);
        end
      end else if (exp_b.size() > 0 && exp_b[0].due <= cyc) begin
        void'(exp_b.pop_front());
        chk("b_rvalid_missing", 0, 1);
      end
    end
  end

  function automatic logic [63:0] outs();
    return 64'({bus.clr_busy, bus.clr_done, bus.a_gnt, bus.a_rvalid, bus.a_rdata,
                bus.b_gnt, bus.b_rvalid, bus.b_rdata, bus.ram_cs, bus.ram_write,
                bus.ram_addr, bus.ram_din});
  endfunction

  function automatic void accept(bit port, bit we, logic [AW-1:0] addr, logic [DW-1:0] d);
    m_cmd_valid = 1'b1;
    m_cmd_we    = we;
    m_cmd_addr  = addr;
    m_cmd_din   = d;
    m_last_b    = port;
    if (we) m_mem[addr] = d;
    else if (port) exp_b.push_back('{m_mem[addr], cyc + 3});
    else           exp_a.push_back('{m_mem[addr], cyc + 3});
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input bit clr);
    bit eg_a, eg_b;
    int idx;
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
    bus.clr_req = clr;
    @(negedge clk);
    idx = 0;
    if (m_clear_left > 0) begin
      idx = DEPTH - m_clear_left;
      if (!(bus.clr_busy && !bus.clr_done && bus.ram_cs && bus.ram_write &&
            bus.ram_addr == AW'(idx) && bus.ram_din == '0)) sweep_err++;
      busy_cycles++;
      eg_a = 1'b0;
      eg_b = 1'b0;
    end else begin
      chk("clr_busy", bus.clr_busy, 0);
      chk("clr_done", bus.clr_done, m_done_next);
      if (m_cmd_valid) begin
        chk("ram_cs", bus.ram_cs, 1);
        chk("ram_write", bus.ram_write, m_cmd_we);
        chk("ram_addr", bus.ram_addr, m_cmd_addr);
        chk("ram_din", bus.ram_din, m_cmd_din);
      end else begin
        chk("ram_idle", {bus.ram_cs, bus.ram_write}, 0);
      end
      eg_a = ar && !clr && (!br || m_last_b);
      eg_b = br && !clr && (!ar || !m_last_b);
    end
    dut_ag = bus.a_gnt;
    dut_bg = bus.b_gnt;
    chk("a_gnt", dut_ag, eg_a);
    chk("b_gnt", dut_bg, eg_b);

    m_done_next = 1'b0;
    m_cmd_valid = 1'b0;
    if (m_clear_left > 0) begin
      m_mem[idx] = '0;
      m_clear_left--;
      if (m_clear_left == 0) begin
        m_done_next = 1'b1;
        chk("clear_sweep_errors", sweep_err, 0);
        chk("clear_busy_cycles", busy_cycles, DEPTH);
      end
    end else if (clr) begin
      m_clear_left = DEPTH;
      sweep_err    = 0;
      busy_cycles  = 0;
    end else if (eg_a) accept(1'b0, aw, aa, ad);
    else if (eg_b)     accept(1'b1, bw, ba, bd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic a_op(input bit we, input int addr, input int data);
    step(1, we, AW'(addr), DW'(data), 0, 0, '0, '0, 0);
  endtask

  // Asynchronous reset mid-cycle; outputs must drop at once and stay 0 with random side inputs.
  task automatic do_reset(input int cycles);
    #1;
    rst_n = 1'b0;
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    #1;
    chk("reset_outputs", outs(), 0);
    repeat (cycles) begin
      bus.clr_req = 1'($urandom);
      bus.a_we = 1'($urandom); bus.a_addr = AW'($urandom); bus.a_wdata = DW'($urandom);
      bus.b_we = 1'($urandom); bus.b_addr = AW'($urandom); bus.b_wdata = DW'($urandom);
      @(negedge clk);
      chk("reset_outputs", outs(), 0);
    end
    m_clear_left = 0;
    m_done_next  = 1'b0;
    m_last_b     = 1'b1;
    m_cmd_valid  = 1'b0;
    exp_a.delete();
    exp_b.delete();
    bus.clr_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ga, gb;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    bus.clr_req = 1'b0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    do_reset(5);
    a_op(1, 5, 21);
    idle(2);

    // Contention from reset: A first, then strict alternation.
    do_reset(2);
    ga = 0;
    gb = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, 1, AW'(k), DW'(k + 100), 1, 1, AW'(k + 8), DW'(k + 200), 0);
      ga += int'(dut_ag);
      gb += int'(dut_bg);
    end
    chk("contention_a_grants", ga, 4);
    chk("contention_b_grants", gb, 4);
    idle(2);

    // Fill then read back on port A only.
    for (int k = 0; k < DEPTH; k++) a_op(1, k, k);
    for (int k = 1; k <= 1000; k++) a_op(0, k, 0);
    idle(5);

    // Read accepted just before a clear, then clear beating a simultaneous A request.
    a_op(0, 10, 0);
    step(1, 0, AW'(11), '0, 0, 0, '0, '0, 1);
    for (int i = 0; i <= DEPTH; i++)
      step(0, 0, '0, '0, 1, 0, AW'(7), '0, (i < 4));
    a_op(0, 1023, 0);
    idle(5);

    // Reset while the sweep is driving address 300.
    a_op(1, 299, 299);
    a_op(1, 500, 500);
    idle(2);
    step(0, 0, '0, '0, 0, 0, '0, '0, 1);
    idle(300);
    do_reset(3);
    idle(3);
    a_op(0, 299, 0);
    a_op(0, 500, 0);
    idle(5);

    // Random mixed traffic on both ports.
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom), DW'($urandom),
           ($urandom_range(0, 2) != 0), 1'($urandom), AW'($urandom), DW'($urandom), 0);
    idle(6);

    chk("a_scoreboard_drained", exp_a.size(), 0);
    chk("b_scoreboard_drained", exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester round-robin arbiter and hardware clear sequencer for the single-port 1024x10 `ram_reset` memory. It drives the RAM's `chip_select`, `write`, `address` and `data_in` pins, and returns read data from `data_out` to the requester that issued the read. On request it runs a full-array clear that writes zero to every word. It sits between the block's two internal masters and the RAM macro, and is the only driver of the RAM command pins.

## Interface
- AW, 10, address width; DEPTH = 2**AW words
- DW, 10, data width

- clk_reset  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- clr_req  in  1  request a full-array clear; level-sampled
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last clear write
- a_req  in  1  port A access request
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  AW  port A address
- a_wdata  in  DW  port A write data
- a_gnt  out  1  port A accepted this cycle (combinational)
- a_rvalid  out  1  port A read data valid (one-cycle pulse)
- a_rdata  out  DW  port A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
- ram_cs  out  1  to RAM chip_select
- ram_write  out  1  to RAM write
- ram_addr  out  AW  to RAM address
- ram_din  out  DW  to RAM data_in
- ram_dout  in  DW  from RAM data_out

## Operation
- States: IDLE, CLEAR.
- **IDLE, request acceptance**
  - `x_gnt` = `x_req` & the arbitration winner & !`clr_req`.
  - An access is accepted when `req` & `gnt` are both high at a rising edge. The requester must hold `we`, `addr` and `wdata` stable while `req` is high.
- **Arbitration**
  - With a single requester active, that requester wins.
  - With both active, the winner is the requester not granted most recently.
  - After reset, A has priority.
  - The last-grant pointer updates only on an accepted access.
- **Command**
  - An access accepted at edge E drives `ram_cs`=1, `ram_write`=`we`, `ram_addr`, `ram_din` for exactly the cycle after E.
  - When no access is accepted, `ram_cs`=0 and `ram_write`=0. `ram_addr` and `ram_din` hold their last values.
- **Reads**
  - The RAM presents `ram_dout` in the cycle after the command cycle.
  - The controller registers it into `x_rdata` and pulses `x_rvalid` for the originating port one cycle later.
  - A 1-bit owner tag is pipelined alongside each command to route the data.
  - `x_rdata` holds its value until the next read for that port.
- **Clear**
  - In IDLE, `clr_req`=1 at an edge moves the block to CLEAR. `clr_req` beats any pending `req` in that cycle: both `gnt` outputs are 0.
  - CLEAR issues DEPTH consecutive writes (`ram_cs`=1, `ram_write`=1, `ram_din`=0) to addresses 0..DEPTH-1, one per cycle.
  - The block then returns to IDLE and pulses `clr_done`.
  - Both `gnt` outputs are 0 throughout CLEAR.
  - `clr_req` is ignored while in CLEAR.
- **Clear counter**
  - AW bits wide; the sweep terminates at DEPTH-1 and does not wrap.
  - Reads already in flight when CLEAR starts still complete and deliver `rvalid`.
- **Reset**
  - Asserting `reset` low at any time forces IDLE and the A-priority pointer, and clears the read pipeline.
  - A clear that is cut short by reset emits no `clr_done`.
  - Reset does not alter RAM contents.
- **Reset value of every output:** 0 (`a_gnt`, `b_gnt` are 0 because `req` inputs must be 0 in reset).

## Timing
- Accept at edge E → RAM command in cycle E+1 → `ram_dout` in E+2 → `x_rvalid`/`x_rdata` in E+3.
- Read latency is 3 cycles from accept.
- A write is complete at the end of E+1.
- Throughput is one access per cycle. Back-to-back accepts from the same or alternating ports are allowed. Holding `req` high issues one access per cycle.
- Read after write to the same address, accepted on consecutive edges, returns the new data.
- **Clear accepted at edge C0:**
  - `clr_busy`=1 in cycles C0+1 .. C0+DEPTH, with `ram_addr`=0 .. DEPTH-1 respectively.
  - `clr_done`=1 and `clr_busy`=0 in cycle C0+DEPTH+1.
  - `gnt` can be reasserted in cycle C0+DEPTH+1.

## Test plan
- **Reset:** hold `reset`=0 with random inputs → every output 0. Release, then `a_req` write addr 5 data 21 → `a_gnt`=1, and the next cycle shows `ram_cs`=1, `ram_write`=1, `ram_addr`=5, `ram_din`=21.
- **Fill and read-back:** port A writes k to addr k for k=0..1023 back-to-back, then reads 1..1000 → each `a_rvalid` 3 cycles after accept with `a_rdata`=k, and `b_rvalid` never asserts.
- **Contention:** `a_req` and `b_req` both held high for 8 cycles → grants alternate A,B,A,B…. A goes first after reset, and each port gets 4 grants.
- **Clear:** after the fill, pulse `clr_req` → `clr_busy` high exactly 1024 cycles and the addresses sweep 0..1023 with `ram_din`=0. Then `clr_done` pulses once and reads of addr 7 and 1023 return 0. A `b_req` during the clear sees `b_gnt`=0 until the `clr_done` cycle.
- **Simultaneous:** `clr_req` and `a_req` high in the same IDLE cycle → `a_gnt`=0 and CLEAR starts. A port A read accepted on the edge just before `clr_req` still returns its data with `a_rvalid`.
- **Reset mid-clear:** assert `reset` at clear address 300 → outputs 0 immediately and no `clr_done`. After release, addr 299 reads 0 and addr 500 reads its pre-clear value 500.
